// File: rtl/bus_activity_detect.sv
// Per-channel synchronizer, glitch filter and edge-pulse generator feeding the
// front-panel activity LED stretchers. Also exports the filtered line levels.
module bus_activity_detect #(
  parameter int N             = 4,
  parameter int FILTER_CYCLES = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] din,
  input  logic [N-1:0] rise_en,
  input  logic [N-1:0] fall_en,
  output logic [N-1:0] filt,
  output logic [N-1:0] pulse
);

  localparam int            CW       = $clog2(FILTER_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(FILTER_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic [N-1:0]  s1;
  logic [N-1:0]  s2;
  logic [N-1:0]  filt_next;
  logic [N-1:0]  pulse_next;
  logic [CW-1:0] cnt      [N];
  logic [CW-1:0] cnt_next [N];

  // Two-flop synchronizer; s2 is the only view of din the filter ever sees.
  // NOTE: sequential state uses non-blocking assignments so s2 takes the old s1,
  // giving two real flop stages regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= din;
      s2 <= s1;
    end
  end

  // A differing level must persist FILTER_CYCLES clocks; any return to the
  // accepted level restarts the count, so short glitches never reach filt.
  always_comb begin
    // NOTE: defaults are assigned before any branch so no path leaves a
    // variable holding its old value, which would infer a latch.
    filt_next = filt;
    for (int i = 0; i < N; i++) begin
      cnt_next[i] = '0;
      if (s2[i] != filt[i]) begin
        if (cnt[i] == CNT_LAST) begin
          filt_next[i] = s2[i];
        end else begin
          cnt_next[i] = cnt[i] + CNT_ONE;
        end
      end
    end
  end

  // Pulse is registered alongside filt so it lines up with the new level.
  assign pulse_next = (filt_next & ~filt & rise_en)
                    | (~filt_next & filt & fall_en);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      filt  <= '0;
      pulse <= '0;
      // NOTE: the counter array is reset too; a stale count surviving reset
      // would let a line be accepted before a full filter window.
      for (int i = 0; i < N; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      filt  <= filt_next;
      pulse <= pulse_next;
      for (int i = 0; i < N; i++) begin
        cnt[i] <= cnt_next[i];
      end
    end
  end

endmodule

// File: tb/tb_bus_activity_detect.sv
// Directed bench for bus_activity_detect: reset, glitch rejection, edge select,
// simultaneous edges, chatter, mid-filter reset and the FILTER_CYCLES=1 case.
`timescale 1ns/1ps
module tb_bus_activity_detect;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] din;
  logic [3:0] rise_en;
  logic [3:0] fall_en;
  logic [3:0] filt;
  logic [3:0] pulse;
  logic [3:0] filt1;
  logic [3:0] pulse1;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  bus_activity_detect #(.N(4), .FILTER_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .din(din), .rise_en(rise_en), .fall_en(fall_en),
    .filt(filt), .pulse(pulse)
  );

  bus_activity_detect #(.N(4), .FILTER_CYCLES(1)) dut_f1 (
    .clk(clk), .rst(rst), .din(din), .rise_en(rise_en), .fall_en(fall_en),
    .filt(filt1), .pulse(pulse1)
  );

  // Inputs change and outputs are sampled 1 ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle(input logic [3:0] d);
    din = d;
    repeat (10) tick();
  endtask

  task automatic test_reset();
    logic [3:0] exp_f, exp_p;
    rst = 1'b1; din = 4'hF; rise_en = 4'hF; fall_en = 4'h0;
    for (int k = 1; k <= 3; k++) begin
      tick();
      n_cmp++; if (filt !== 4'h0) begin n_err++; $display("FAIL reset_hold filt got %h want 0", filt); end
      n_cmp++; if (pulse !== 4'h0) begin n_err++; $display("FAIL reset_hold pulse got %h want 0", pulse); end
    end
    rst = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      tick();
      exp_f = (k >= 6) ? 4'hF : 4'h0;
      exp_p = (k == 6) ? 4'hF : 4'h0;
      n_cmp++; if (filt !== exp_f) begin n_err++; $display("FAIL reset_release k=%0d filt got %h want %h", k, filt, exp_f); end
      n_cmp++; if (pulse !== exp_p) begin n_err++; $display("FAIL reset_release k=%0d pulse got %h want %h", k, pulse, exp_p); end
    end
  endtask

  task automatic test_glitch();
    rise_en = 4'hF; fall_en = 4'h0;
    settle(4'h0);
    for (int k = 1; k <= 12; k++) begin
      din = (k <= 3) ? 4'h1 : 4'h0;
      tick();
      n_cmp++; if (filt !== 4'h0) begin n_err++; $display("FAIL glitch k=%0d filt got %h want 0", k, filt); end
      n_cmp++; if (pulse !== 4'h0) begin n_err++; $display("FAIL glitch k=%0d pulse got %h want 0", k, pulse); end
    end
  endtask

  task automatic test_clean_rise();
    logic [3:0] exp_f, exp_p;
    rise_en = 4'h2; fall_en = 4'h0;
    din = 4'h2;
    for (int k = 1; k <= 10; k++) begin
      tick();
      exp_f = (k >= 6) ? 4'h2 : 4'h0;
      exp_p = (k == 6) ? 4'h2 : 4'h0;
      n_cmp++; if (filt !== exp_f) begin n_err++; $display("FAIL clean_rise k=%0d filt got %h want %h", k, filt, exp_f); end
      n_cmp++; if (pulse !== exp_p) begin n_err++; $display("FAIL clean_rise k=%0d pulse got %h want %h", k, pulse, exp_p); end
    end
  endtask

  task automatic test_edge_select();
    logic [3:0] exp_f, exp_p;
    rise_en = 4'h0; fall_en = 4'h0;
    settle(4'h0);
    fall_en = 4'h4;
    din = 4'h4;
    for (int k = 1; k <= 8; k++) begin
      tick();
      exp_f = (k >= 6) ? 4'h4 : 4'h0;
      n_cmp++; if (filt !== exp_f) begin n_err++; $display("FAIL edge_sel_rise k=%0d filt got %h want %h", k, filt, exp_f); end
      n_cmp++; if (pulse !== 4'h0) begin n_err++; $display("FAIL edge_sel_rise k=%0d pulse got %h want 0", k, pulse); end
    end
    din = 4'h0;
    for (int k = 1; k <= 8; k++) begin
      tick();
      exp_f = (k >= 6) ? 4'h0 : 4'h4;
      exp_p = (k == 6) ? 4'h4 : 4'h0;
      n_cmp++; if (filt !== exp_f) begin n_err++; $display("FAIL edge_sel_fall k=%0d filt got %h want %h", k, filt, exp_f); end
      n_cmp++; if (pulse !== exp_p) begin n_err++; $display("FAIL edge_sel_fall k=%0d pulse got %h want %h", k, pulse, exp_p); end
    end
  endtask

  task automatic test_simultaneous();
    logic [3:0] exp_f, exp_p;
    logic       b3;
    rise_en = 4'hF; fall_en = 4'h0;
    din = 4'hF;
    for (int k = 1; k <= 8; k++) begin
      tick();
      exp_f = (k >= 6) ? 4'hF : 4'h0;
      exp_p = (k == 6) ? 4'hF : 4'h0;
      n_cmp++; if (filt !== exp_f) begin n_err++; $display("FAIL simul k=%0d filt got %h want %h", k, filt, exp_f); end
      n_cmp++; if (pulse !== exp_p) begin n_err++; $display("FAIL simul k=%0d pulse got %h want %h", k, pulse, exp_p); end
    end
    // Channel 3 chatters with 2-clock phases; both edge enables armed.
    fall_en = 4'hF;
    for (int k = 1; k <= 24; k++) begin
      b3 = (k <= 20) ? ((((k - 1) / 2) % 2) == 1) : 1'b1;
      din = {b3, 3'b111};
      tick();
      n_cmp++; if (filt !== 4'hF) begin n_err++; $display("FAIL chatter k=%0d filt got %h want F", k, filt); end
      n_cmp++; if (pulse !== 4'h0) begin n_err++; $display("FAIL chatter k=%0d pulse got %h want 0", k, pulse); end
    end
    fall_en = 4'h0;
    settle(4'h0);
  endtask

  task automatic test_midop_reset();
    logic [3:0] exp_f, exp_p;
    rise_en = 4'h1; fall_en = 4'h0;
    din = 4'h1;
    for (int k = 1; k <= 4; k++) begin
      tick();
      n_cmp++; if (pulse !== 4'h0) begin n_err++; $display("FAIL midop_pre k=%0d pulse got %h want 0", k, pulse); end
    end
    rst = 1'b1;
    tick();
    n_cmp++; if (filt !== 4'h0) begin n_err++; $display("FAIL midop_rst filt got %h want 0", filt); end
    n_cmp++; if (pulse !== 4'h0) begin n_err++; $display("FAIL midop_rst pulse got %h want 0", pulse); end
    rst = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      tick();
      exp_f = (k >= 6) ? 4'h1 : 4'h0;
      exp_p = (k == 6) ? 4'h1 : 4'h0;
      n_cmp++; if (filt !== exp_f) begin n_err++; $display("FAIL midop_post k=%0d filt got %h want %h", k, filt, exp_f); end
      n_cmp++; if (pulse !== exp_p) begin n_err++; $display("FAIL midop_post k=%0d pulse got %h want %h", k, pulse, exp_p); end
    end
  endtask

  // FILTER_CYCLES=1 instance: a one-clock blip passes with one clock of delay
  // after the synchronizer, giving back-to-back rise and fall pulses.
  task automatic test_filter1();
    logic [3:0] exp_f, exp_p;
    rise_en = 4'hF; fall_en = 4'hF;
    settle(4'h0);
    for (int k = 1; k <= 6; k++) begin
      din = (k == 1) ? 4'h1 : 4'h0;
      tick();
      exp_f = (k == 3) ? 4'h1 : 4'h0;
      exp_p = (k == 3 || k == 4) ? 4'h1 : 4'h0;
      n_cmp++; if (filt1 !== exp_f) begin n_err++; $display("FAIL filter1 k=%0d filt got %h want %h", k, filt1, exp_f); end
      n_cmp++; if (pulse1 !== exp_p) begin n_err++; $display("FAIL filter1 k=%0d pulse got %h want %h", k, pulse1, exp_p); end
      n_cmp++; if (filt !== 4'h0) begin n_err++; $display("FAIL filter4_blip k=%0d filt got %h want 0", k, filt); end
    end
  endtask

  initial begin
    test_reset();
    test_glitch();
    test_clean_rise();
    test_edge_select();
    test_simultaneous();
    test_midop_reset();
    test_filter1();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
